motor_throttle_pwm: RTL

Consumer end of the 8-bit `MotorSignal` speed command produced by the current-control loop. It converts the command into the PWM throttle waveform that drives the commercial motor controller's hall-throttle input, which expects a 0.8–4.2 V range after the board RC filter. The block slew-limits the command and forces idle throttle on brake or disable. It runs on the 20 kHz system tick.

---
 rtl/motor_throttle_pwm_if.sv | 27 ++
 rtl/motor_throttle_pwm.sv | 133 +++++++++++++
 2 files changed

// File: rtl/motor_throttle_pwm_if.sv
// Throttle command/observation bundle between the current loop and the PWM throttle stage.
interface motor_throttle_pwm_if;
    logic       Enable;
    logic       Brake;
    logic [7:0] MotorSignal;
    logic       ThrottlePWM;
    logic [7:0] ThrottleLevel;
    logic       Ramping;

    modport master (
        output Enable,
        output Brake,
        output MotorSignal,
        input  ThrottlePWM,
        input  ThrottleLevel,
        input  Ramping
    );

    modport slave (
        input  Enable,
        input  Brake,
        input  MotorSignal,
        output ThrottlePWM,
        output ThrottleLevel,
        output Ramping
    );
endinterface

// File: rtl/motor_throttle_pwm.sv
// Slew-limited 8-bit speed command to 256-clock PWM hall-throttle waveform; idle on brake/disable.
// Command sampled at period boundaries (1-256 clk); brake/disable in 1 clk. Macro THROTTLE_SLEW_EN enables slew.
module motor_throttle_pwm #(
    parameter int unsigned MIN_DUTY  = 41,
    parameter int unsigned MAX_DUTY  = 215,
    parameter int unsigned SLEW_STEP = 4
) (
    input  logic                 c20k,
    input  logic                 reset,
    motor_throttle_pwm_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RAMP  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;

    localparam logic [7:0] MIN_D = 8'(MIN_DUTY);
    localparam logic [7:0] SPAN  = 8'(MAX_DUTY - MIN_DUTY);

    if (!(MIN_DUTY < MAX_DUTY && MAX_DUTY <= 255)) begin : g_bad_duty
        $error("motor_throttle_pwm: MIN_DUTY < MAX_DUTY <= 255 violated");
    end
    if (SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_bad_step
        $error("motor_throttle_pwm: SLEW_STEP outside 1..255");
    end

    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] level;
    logic [7:0] level_next;
    logic [7:0] duty;
    logic [7:0] duty_next;
    logic       pwm;
    logic       boundary;
    logic       force_idle;
    logic [7:0] cmd;

    // (level+1)*span/256 keeps both ends exact: 0 -> MIN_DUTY, 255 -> MAX_DUTY.
    function automatic logic [7:0] duty_of(input logic [7:0] lvl);
        logic [15:0] prod;
        prod = 16'(lvl) * 16'(SPAN) + 16'(SPAN);
        return MIN_D + prod[15:8];
    endfunction

    assign cnt_next   = cnt + 8'd1;
    assign boundary   = (cnt == 8'hFF);
    assign force_idle = bus.Brake | ~bus.Enable;
    assign cmd        = bus.MotorSignal;

`ifdef THROTTLE_SLEW_EN
    localparam logic [7:0] STEP = 8'(SLEW_STEP);

    logic [8:0]        up_sum;
    logic signed [9:0] dn_diff;
    logic [7:0]        stepped;

    // Nine/ten-bit intermediates so the step saturates instead of wrapping.
    always_comb begin
        up_sum  = {1'b0, level} + {1'b0, STEP};
        dn_diff = $signed({2'b00, level}) - $signed({2'b00, STEP});
        stepped = level;
        if (cmd > level) begin
            stepped = (up_sum > {1'b0, cmd}) ? cmd : up_sum[7:0];
        end else if (cmd < level) begin
            stepped = (dn_diff < $signed({2'b00, cmd})) ? cmd : dn_diff[7:0];
        end
    end
`endif

    always_comb begin
        state_next = state;
        level_next = level;
        duty_next  = duty;
        if (force_idle) begin
            state_next = ST_IDLE;
            level_next = 8'd0;
            duty_next  = MIN_D;
        end else if (boundary) begin
            case (state)
                ST_RAMP: begin
`ifdef THROTTLE_SLEW_EN
                    level_next = stepped;
                    state_next = (stepped == cmd) ? ST_TRACK : ST_RAMP;
`else
                    level_next = cmd;
                    state_next = ST_TRACK;
`endif
                end
                default: begin
`ifdef THROTTLE_SLEW_EN
                    if (cmd != level) begin
                        level_next = stepped;
                        state_next = ST_RAMP;
                    end else begin
                        state_next = ST_TRACK;
                    end
`else
                    level_next = cmd;
                    state_next = ST_TRACK;
`endif
                end
            endcase
            duty_next = duty_of(level_next);
        end
    end

    always_ff @(posedge c20k or posedge reset) begin
        if (reset) begin
            cnt   <= 8'hFF;
            state <= ST_IDLE;
            level <= 8'd0;
            duty  <= MIN_D;
            pwm   <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            state <= state_next;
            level <= level_next;
            duty  <= duty_next;
            pwm   <= (cnt_next < duty_next);
        end
    end

    assign bus.ThrottlePWM   = pwm;
    assign bus.ThrottleLevel = level;
`ifdef THROTTLE_SLEW_EN
    assign bus.Ramping = (state == ST_RAMP);
`else
    assign bus.Ramping = 1'b0;
`endif

endmodule
